// File: rtl/twiddle_fetch_seq_if.sv
// Twiddle stream bundle between the fetch sequencer and the FFT butterfly.
// The master drives the word and its tags; the slave returns ready.
interface twiddle_fetch_seq_if #(
  parameter int MEM_WIDTH = 32,
  parameter int AW        = 6
);
  logic                 tw_valid;
  logic                 tw_ready;
  logic [MEM_WIDTH-1:0] tw_data;
  logic [AW-1:0]        tw_index;
  logic                 tw_last;

  modport master (
    output tw_valid,
    output tw_data,
    output tw_index,
    output tw_last,
    input  tw_ready
  );

  modport slave (
    input  tw_valid,
    input  tw_data,
    input  tw_index,
    input  tw_last,
    output tw_ready
  );
endinterface

// File: rtl/twiddle_fetch_seq.sv
// Strided, wrapping address sequencer for the twiddle ROM with a small
// credit-managed output buffer toward the FFT butterfly.
module twiddle_fetch_seq #(
  parameter  int MEM_WIDTH  = 32,
  parameter  int MEM_DEPTH  = 64,
  parameter  int FIFO_DEPTH = 3,
  localparam int AW         = $clog2(MEM_DEPTH)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [AW-1:0]        start_addr,
  input  logic [AW-1:0]        stride,
  input  logic [AW:0]          count,
  output logic                 busy,
  output logic                 done,
  output logic                 rom_enable,
  output logic [AW-1:0]        rom_address,
  input  logic [MEM_WIDTH-1:0] rom_dout,
  twiddle_fetch_seq_if.master  tw
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef logic [AW:0] cnt_t;
  localparam cnt_t ONE = cnt_t'(1);

  typedef struct packed {
    logic                 last;
    logic [AW-1:0]        idx;
    logic [MEM_WIDTH-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  state_t        state;
  state_t        state_n;

  logic [AW-1:0] addr_q;
  logic [AW-1:0] stride_q;
  logic [AW-1:0] last_addr;
  cnt_t          count_q;
  cnt_t          issue_cnt;
  cnt_t          pop_cnt;

  logic          pending;
  logic [AW-1:0] pend_idx;
  logic          pend_last;

  entry_t        mem [FIFO_DEPTH];
  entry_t        head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] fifo_count;

  logic          done_q;
  logic          accept;
  logic          issue;
  logic          push;
  logic          pop;
  logic          credit;
  logic          last_issue;
  logic          done_n;
  logic [CW:0]   used;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(FIFO_DEPTH - 1)) ?
      '0 : p + 1'b1;
  endfunction

  // Words in the buffer plus the one still in
  // flight from the ROM bound the credit.
  assign used   = {1'b0, fifo_count}
                + {{CW{1'b0}}, pending};
  assign credit = used < (CW+1)'(FIFO_DEPTH);

  assign push       = pending;
  assign pop        = tw.tw_valid & tw.tw_ready;
  assign last_issue = issue_cnt == count_q - ONE;

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    issue   = 1'b0;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !done_q) begin
          accept  = 1'b1;
          state_n = (count == '0) ? DRAIN : ISSUE;
        end
      end
      ISSUE: begin
        if (credit) begin
          issue = 1'b1;
          if (last_issue) begin
            state_n = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop_cnt + cnt_t'(pop) == count_q) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      done_q    <= 1'b0;
      addr_q    <= '0;
      stride_q  <= '0;
      last_addr <= '0;
      count_q   <= '0;
      issue_cnt <= '0;
      pop_cnt   <= '0;
      pending   <= 1'b0;
      pend_idx  <= '0;
      pend_last <= 1'b0;
    end else begin
      state   <= state_n;
      done_q  <= done_n;
      pending <= issue;
      if (accept) begin
        addr_q    <= start_addr;
        stride_q  <= stride;
        count_q   <= count;
        issue_cnt <= '0;
        pop_cnt   <= '0;
      end
      if (issue) begin
        addr_q    <= addr_q + stride_q;
        last_addr <= addr_q;
        issue_cnt <= issue_cnt + ONE;
        pend_idx  <= issue_cnt[AW-1:0];
        pend_last <= last_issue;
      end
      if (pop) begin
        pop_cnt <= pop_cnt + ONE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{
          last: pend_last,
          idx:  pend_idx,
          data: rom_dout
        };
        wr_ptr <= nxt(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= nxt(rd_ptr);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  a_no_overflow: assert property (
    @(posedge clock) disable iff (!reset_n)
    (push && !pop) |-> (fifo_count != CW'(FIFO_DEPTH))
  );

  assign head        = mem[rd_ptr];
  assign tw.tw_valid = fifo_count != '0;
  assign tw.tw_data  = tw.tw_valid ? head.data : '0;
  assign tw.tw_index = tw.tw_valid ? head.idx  : '0;
  assign tw.tw_last  = tw.tw_valid & head.last;

  assign rom_enable  = issue;
  assign rom_address = issue ? addr_q : last_addr;
  assign busy        = state != IDLE;
  assign done        = done_q;

endmodule

// File: tb/tb_twiddle_fetch_seq.sv
// Randomized scoreboard bench for the twiddle fetch sequencer.
// Expected words come from a ROM-table reference model of the address walk.
module tb_twiddle_fetch_seq;
  localparam int W  = 32;
  localparam int D  = 64;
  localparam int AW = 6;

  typedef struct {
    logic [W-1:0]  d;
    logic [AW-1:0] idx;
    logic          last;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [AW-1:0] stride;
  logic [AW:0]   count;
  logic          busy;
  logic          done;
  logic          rom_enable;
  logic [AW-1:0] rom_address;
  logic [W-1:0]  rom_dout;

  twiddle_fetch_seq_if #(.MEM_WIDTH(W), .AW(AW)) tw ();

  twiddle_fetch_seq #(
    .MEM_WIDTH (W),
    .MEM_DEPTH (D),
    .FIFO_DEPTH(3)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .start_addr (start_addr),
    .stride     (stride),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .rom_enable (rom_enable),
    .rom_address(rom_address),
    .rom_dout   (rom_dout),
    .tw         (tw.master)
  );

  always #5 clock = ~clock;

  logic [W-1:0] rom [D];
  always @(posedge clock)
    if (rom_enable) rom_dout <= rom[rom_address];

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  function automatic void chk(string n, logic [31:0] a,
                              logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endfunction

  exp_t         eq[$];
  int           aq[$];
  logic [W-1:0] seen[$];
  int  issued, popped, base;
  int  first_v, last_v, nvalid, ndone, done_cyc;
  bit  bp = 0, skip_stab = 0;
  bit  pv = 0, pr = 0;
  logic [W-1:0] pd = '0;

  function automatic void model(int sa, int st, int cnt);
    for (int i = 0; i < cnt; i++) begin
      int a;
      exp_t e;
      a = (sa + i * st) % D;
      e.d = rom[a];
      e.idx = AW'(i);
      e.last = (i == cnt - 1);
      eq.push_back(e);
      aq.push_back(a);
    end
  endfunction

  always @(negedge clock) begin
    if (reset_n && rom_enable) begin
      chk("credit", (issued - popped) < 3, 1);
      if (aq.size() == 0) begin
        chk("extra_read", 1, 0);
      end else begin
        chk("rom_address", rom_address, aq.pop_front());
      end
      issued++;
    end
    if (!skip_stab && pv && !pr) begin
      chk("stall_valid", tw.tw_valid, 1);
      chk("stall_data", tw.tw_data, pd);
    end
    if (tw.tw_valid) begin
      if (first_v < 0) first_v = cyc - base;
      last_v = cyc - base;
      nvalid++;
    end
    if (tw.tw_valid && tw.tw_ready) begin
      if (eq.size() == 0) begin
        chk("extra_word", tw.tw_data, 0);
      end else begin
        exp_t e;
        e = eq.pop_front();
        chk("tw_data", tw.tw_data, e.d);
        chk("tw_index", tw.tw_index, e.idx);
        chk("tw_last", tw.tw_last, e.last);
      end
      seen.push_back(tw.tw_data);
      popped++;
    end
    if (done) begin
      ndone++;
      done_cyc = cyc - base;
    end
    pv = tw.tw_valid;
    pr = tw.tw_ready;
    pd = tw.tw_data;
  end

  initial begin
    tw.tw_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      tw.tw_ready = bp ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  task automatic check_zero(string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rom_en"}, rom_enable, 0);
    chk({tag, "_rom_addr"}, rom_address, 0);
    chk({tag, "_valid"}, tw.tw_valid, 0);
    chk({tag, "_data"}, tw.tw_data, 0);
    chk({tag, "_index"}, tw.tw_index, 0);
    chk({tag, "_last"}, tw.tw_last, 0);
  endtask

  task automatic run(input int sa, input int st, input int cnt,
                     input bit bpm, input int inject,
                     input int rst_word);
    bit got = 0;
    bit did_rst = 0;
    bp = bpm;
    first_v = -1; last_v = -1; nvalid = 0;
    ndone = 0; done_cyc = -1;
    seen.delete();
    model(sa, st, cnt);
    @(posedge clock); #1;
    start = 1'b1;
    start_addr = AW'(sa);
    stride = AW'(st);
    count = (AW+1)'(cnt);
    @(posedge clock); #1;
    start = 1'b0;
    base = cyc - 1;
    start_addr = AW'($urandom);
    stride = AW'($urandom);
    count = (AW+1)'($urandom_range(0, 64));
    for (int k = 0; k < 3000; k++) begin
      @(negedge clock);
      start = (k == inject);
      if (rst_word >= 0 && popped >= rst_word) begin
        skip_stab = 1;
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        check_zero("midrst");
        eq.delete(); aq.delete();
        issued = 0; popped = 0; pv = 0;
        ndone = 0;
        repeat (10) @(negedge clock);
        chk("midrst_no_done", ndone, 0);
        skip_stab = 0;
        did_rst = 1;
        got = 1;
        break;
      end
      if (done) begin
        chk("busy_at_done", busy, 0);
        got = 1;
        break;
      end
    end
    start = 1'b0;
    bp = 0;
    if (!got) chk("done_timeout", 0, 1);
    #1;
    if (!did_rst) begin
      chk("leftover", eq.size(), 0);
      chk("done_once", ndone, 1);
    end
  endtask

  initial begin
    for (int i = 0; i < D; i++)
      rom[i] = 32'h4000_0000 + i * 32'h0001_0203;
    rom[0]  = 32'h3f68c7b7;
    rom[1]  = 32'h3f65567d;
    rom[5]  = 32'h3f555dbb;
    rom[16] = 32'h3f193578;
    rom[32] = 32'h3e1081c3;
    rom[48] = 32'hbeb399db;
    rom[62] = 32'hbf36e963;
    rom[63] = 32'h3f3c6b25;

    issued = 0; popped = 0; base = 0;
    reset_n = 1'b0; start = 1'b0;
    start_addr = '0; stride = '0; count = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_zero("reset");
    reset_n = 1'b1;

    run(0, 1, 64, 0, -1, -1);
    chk("sweep_first_valid", first_v, 3);
    chk("sweep_last_valid", last_v, 66);
    chk("sweep_nvalid", nvalid, 64);
    chk("sweep_done_cyc", done_cyc, 67);
    chk("sweep_w0", seen[0], 32'h3f68c7b7);
    chk("sweep_w1", seen[1], 32'h3f65567d);
    chk("sweep_w63", seen[63], 32'h3f3c6b25);

    run(62, 1, 4, 0, -1, -1);
    chk("wrap_w0", seen[0], 32'hbf36e963);
    chk("wrap_w1", seen[1], 32'h3f3c6b25);
    chk("wrap_w2", seen[2], 32'h3f68c7b7);
    chk("wrap_w3", seen[3], 32'h3f65567d);

    run(0, 16, 4, 0, -1, -1);
    chk("stride_w0", seen[0], 32'h3f68c7b7);
    chk("stride_w1", seen[1], 32'h3f193578);
    chk("stride_w2", seen[2], 32'h3e1081c3);
    chk("stride_w3", seen[3], 32'hbeb399db);

    run(0, 1, 64, 1, -1, -1);
    chk("bp_words", seen.size(), 64);

    run(7, 3, 0, 0, -1, -1);
    chk("cnt0_done_cyc", done_cyc, 2);
    chk("cnt0_nvalid", nvalid, 0);

    run(0, 3, 20, 1, 8, -1);
    chk("midstart_words", seen.size(), 20);

    run(5, 0, 3, 0, -1, -1);
    chk("stride0_words", seen.size(), 3);
    for (int i = 0; i < 3; i++)
      chk("stride0_w", seen[i], 32'h3f555dbb);

    run(0, 1, 64, 0, -1, 10);
    run(0, 1, 64, 0, -1, -1);
    chk("post_rst_words", seen.size(), 64);
    chk("post_rst_done_cyc", done_cyc, 67);

    for (int r = 0; r < 8; r++) begin
      int c;
      c = $urandom_range(0, 64);
      run($urandom_range(0, 63), $urandom_range(0, 63), c,
          1'($urandom_range(0, 1)), -1, -1);
      chk("rand_words", seen.size(), c);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
